// File: rtl/snoop_bus_controller_pkg.sv
`default_nettype none
// ============================================================================
// snoop_bus_controller_pkg
// ----------------------------------------------------------------------------
// Shared cache definitions for the MOESI L1 snooping bus: address/line
// widths, bus request encoding and the MOESI line-state encoding.
// Ports: none (package).
// Revision: 1.0 - initial release
// ============================================================================
package snoop_bus_controller_pkg;

  localparam int ADDR_BITS      = 32;
  localparam int OFFSET_BITS    = 6;
  localparam int CACHELINE_BITS = 512;
  // Line address: byte address with the in-line offset stripped.
  localparam int LINE_ADDR_BITS = ADDR_BITS - OFFSET_BITS;

  typedef enum logic [1:0] {
    BUS_RD   = 2'd0,
    BUS_RDX  = 2'd1,
    BUS_UPGR = 2'd2,
    BUS_WB   = 2'd3
  } bus_req_t;

  typedef enum logic [2:0] {
    MOESI_I = 3'd0,
    MOESI_S = 3'd1,
    MOESI_E = 3'd2,
    MOESI_O = 3'd3,
    MOESI_M = 3'd4
  } moesi_t;

endpackage
`default_nettype wire

// File: rtl/snoop_bus_controller_rr_arbiter.sv
`default_nettype none
// ============================================================================
// snoop_bus_controller_rr_arbiter
// ----------------------------------------------------------------------------
// Purely combinational round-robin arbiter. The search starts at ptr_i and
// wraps; the first requesting index wins.
// Ports:
//   req_i    in  N_CORES  request vector
//   ptr_i    in  IDX_W    search start index
//   grant_o  out N_CORES  one-hot grant (zero when no request)
//   idx_o    out IDX_W    index of the granted requester
//   valid_o  out 1        any request granted
// Revision: 1.0 - initial release
// ============================================================================
module snoop_bus_controller_rr_arbiter #(
  parameter int N_CORES = 4,
  parameter int IDX_W   = (N_CORES > 1) ? $clog2(N_CORES) : 1
) (
  input  logic [N_CORES-1:0] req_i,
  input  logic [IDX_W-1:0]   ptr_i,
  output logic [N_CORES-1:0] grant_o,
  output logic [IDX_W-1:0]   idx_o,
  output logic               valid_o
);

  always_comb begin : p_search
    logic [IDX_W-1:0] k;
    grant_o = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    k       = '0;
    for (int i = 0; i < N_CORES; i++) begin
      // Modulo keeps the rotated index in range for non-power-of-two N_CORES.
      k = IDX_W'((int'(ptr_i) + i) % N_CORES);
      if (!valid_o && req_i[k]) begin
        valid_o    = 1'b1;
        grant_o[k] = 1'b1;
        idx_o      = k;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/snoop_bus_controller.sv
`default_nettype none
// ============================================================================
// snoop_bus_controller
// ----------------------------------------------------------------------------
// Shared snooping bus controller for the MOESI L1 caches. Arbitrates core
// requests round-robin, broadcasts each accepted request as a snoop to the
// other cores, sources the line from a snoop supplier or from memory and
// returns it (with a shared flag) to the requester. Writebacks go straight
// to memory. One transaction in flight at a time.
// Ports:
//   clk, reset_n                      clock, async active-low reset
//   bus_req_valid/ready/addr/req/data per-core request channel
//   bus_resp_valid/data/shared        response to the requester
//   snoop_valid/addr/req              snoop broadcast
//   snoop_hit/supply/data             snoop replies (cycle after snoop_valid)
//   mem_req_valid/ready/we/addr/data  memory request channel
//   mem_resp_valid/data               memory read data
// Revision: 1.0 - initial release
// ============================================================================
module snoop_bus_controller
  import snoop_bus_controller_pkg::*;
#(
  parameter int N_CORES = 4
) (
  input  logic                                   clk,
  input  logic                                   reset_n,
  input  logic [N_CORES-1:0]                     bus_req_valid,
  output logic [N_CORES-1:0]                     bus_req_ready,
  input  logic [N_CORES-1:0][LINE_ADDR_BITS-1:0] bus_req_addr,
  input  bus_req_t [N_CORES-1:0]                 bus_req,
  input  logic [N_CORES-1:0][CACHELINE_BITS-1:0] bus_req_data,
  output logic [N_CORES-1:0]                     bus_resp_valid,
  output logic [CACHELINE_BITS-1:0]              bus_resp_data,
  output logic                                   bus_resp_shared,
  output logic [N_CORES-1:0]                     snoop_valid,
  output logic [LINE_ADDR_BITS-1:0]              snoop_addr,
  output bus_req_t                               snoop_req,
  input  logic [N_CORES-1:0]                     snoop_hit,
  input  logic [N_CORES-1:0]                     snoop_supply,
  input  logic [N_CORES-1:0][CACHELINE_BITS-1:0] snoop_data,
  output logic                                   mem_req_valid,
  input  logic                                   mem_req_ready,
  output logic                                   mem_req_we,
  output logic [LINE_ADDR_BITS-1:0]              mem_req_addr,
  output logic [CACHELINE_BITS-1:0]              mem_req_data,
  input  logic                                   mem_resp_valid,
  input  logic [CACHELINE_BITS-1:0]              mem_resp_data
);

  localparam int IDX_W = (N_CORES > 1) ? $clog2(N_CORES) : 1;
  localparam int LA    = LINE_ADDR_BITS;
  localparam int CL    = CACHELINE_BITS;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_SNOOP    = 3'd1,
    ST_COLLECT  = 3'd2,
    ST_MEM_REQ  = 3'd3,
    ST_MEM_WAIT = 3'd4,
    ST_RESP     = 3'd5
  } state_t;

  state_t           state_q,  state_d;
  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0] gnt_q,    gnt_d;
  bus_req_t         type_q,   type_d;
  logic [LA-1:0]    addr_q,   addr_d;
  // Holds writeback data on the way to memory, then the response line.
  logic [CL-1:0]    data_q,   data_d;
  logic             shared_q, shared_d;

  logic [N_CORES-1:0] arb_grant;
  logic [IDX_W-1:0]   arb_idx;
  logic               arb_valid;
  logic [N_CORES-1:0] gnt_onehot;
  logic [N_CORES-1:0] others;
  logic [N_CORES-1:0] hit_m;
  logic [N_CORES-1:0] sup_m;
  logic [CL-1:0]      sup_data;

  snoop_bus_controller_rr_arbiter #(
    .N_CORES (N_CORES),
    .IDX_W   (IDX_W)
  ) u_arb (
    .req_i   (bus_req_valid),
    .ptr_i   (rr_ptr_q),
    .grant_o (arb_grant),
    .idx_o   (arb_idx),
    .valid_o (arb_valid)
  );

  assign gnt_onehot = N_CORES'(1) << gnt_q;
  assign others     = ~gnt_onehot;
  // The requester's own snoop lines are ignored: it is not snooped.
  assign hit_m      = snoop_hit    & others;
  assign sup_m      = snoop_supply & others;

  // Lowest-index supplier wins when several claim ownership.
  always_comb begin
    sup_data = '0;
    for (int i = N_CORES - 1; i >= 0; i--) begin
      if (sup_m[i]) sup_data = snoop_data[i];
    end
  end

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    gnt_d    = gnt_q;
    type_d   = type_q;
    addr_d   = addr_q;
    data_d   = data_q;
    shared_d = shared_q;
    case (state_q)
      ST_IDLE: begin
        if (arb_valid) begin
          gnt_d    = arb_idx;
          type_d   = bus_req[arb_idx];
          addr_d   = bus_req_addr[arb_idx];
          data_d   = bus_req_data[arb_idx];
          rr_ptr_d = (arb_idx == IDX_W'(N_CORES - 1)) ? '0 : arb_idx + 1'b1;
          state_d  = (bus_req[arb_idx] == BUS_WB) ? ST_MEM_REQ : ST_SNOOP;
        end
      end
      ST_SNOOP: state_d = ST_COLLECT;
      ST_COLLECT: begin
        shared_d = (type_q == BUS_RD) && (|hit_m);
        if (type_q == BUS_UPGR) begin
          // Requester proceeded on ready; invalidation snoop is all it needs.
          state_d = ST_IDLE;
        end else if (|sup_m) begin
          data_d  = sup_data;
          state_d = ST_RESP;
        end else begin
          state_d = ST_MEM_REQ;
        end
      end
      ST_MEM_REQ: begin
        if (mem_req_ready) begin
          state_d = (type_q == BUS_WB) ? ST_IDLE : ST_MEM_WAIT;
        end
      end
      ST_MEM_WAIT: begin
        if (mem_resp_valid) begin
          data_d  = mem_resp_data;
          state_d = ST_RESP;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      rr_ptr_q <= '0;
      gnt_q    <= '0;
      type_q   <= BUS_RD;
      addr_q   <= '0;
      data_q   <= '0;
      shared_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      gnt_q    <= gnt_d;
      type_q   <= type_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      shared_q <= shared_d;
    end
  end

  // Ready is the only output with a combinational input path; it is also
  // gated by reset_n so it drops the instant reset asserts.
  assign bus_req_ready   = (reset_n && (state_q == ST_IDLE)) ? arb_grant : '0;

  assign snoop_valid     = (state_q == ST_SNOOP) ? others : '0;
  assign snoop_addr      = addr_q;
  assign snoop_req       = type_q;

  assign mem_req_valid   = (state_q == ST_MEM_REQ);
  assign mem_req_we      = (type_q == BUS_WB);
  assign mem_req_addr    = addr_q;
  assign mem_req_data    = data_q;

  assign bus_resp_valid  = (state_q == ST_RESP) ? gnt_onehot : '0;
  assign bus_resp_data   = data_q;
  assign bus_resp_shared = shared_q;

endmodule
`default_nettype wire

// File: tb/tb_snoop_bus_controller.sv
`default_nettype none
// ============================================================================
// tb_snoop_bus_controller
// ----------------------------------------------------------------------------
// Self-checking bench: directed transaction table, multi-cycle sequences
// (round-robin UPGR stream, reset in MEM_WAIT) and randomized transactions
// checked against a transaction-level reference model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_snoop_bus_controller;
  import snoop_bus_controller_pkg::*;

  localparam int N  = 4;
  localparam int LA = LINE_ADDR_BITS;
  localparam int CL = CACHELINE_BITS;

  localparam int P_UPGR = 0;
  localparam int P_SUP  = 1;
  localparam int P_MEM  = 2;
  localparam int P_WB   = 3;

  logic                     clk = 1'b0;
  logic                     reset_n;
  logic [N-1:0]             bus_req_valid;
  logic [N-1:0]             bus_req_ready;
  logic [N-1:0][LA-1:0]     bus_req_addr;
  bus_req_t [N-1:0]         bus_req;
  logic [N-1:0][CL-1:0]     bus_req_data;
  logic [N-1:0]             bus_resp_valid;
  logic [CL-1:0]            bus_resp_data;
  logic                     bus_resp_shared;
  logic [N-1:0]             snoop_valid;
  logic [LA-1:0]            snoop_addr;
  bus_req_t                 snoop_req;
  logic [N-1:0]             snoop_hit;
  logic [N-1:0]             snoop_supply;
  logic [N-1:0][CL-1:0]     snoop_data;
  logic                     mem_req_valid;
  logic                     mem_req_ready;
  logic                     mem_req_we;
  logic [LA-1:0]            mem_req_addr;
  logic [CL-1:0]            mem_req_data;
  logic                     mem_resp_valid;
  logic [CL-1:0]            mem_resp_data;

  always #5 clk = ~clk;

  snoop_bus_controller #(.N_CORES(N)) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .bus_req_valid   (bus_req_valid),
    .bus_req_ready   (bus_req_ready),
    .bus_req_addr    (bus_req_addr),
    .bus_req         (bus_req),
    .bus_req_data    (bus_req_data),
    .bus_resp_valid  (bus_resp_valid),
    .bus_resp_data   (bus_resp_data),
    .bus_resp_shared (bus_resp_shared),
    .snoop_valid     (snoop_valid),
    .snoop_addr      (snoop_addr),
    .snoop_req       (snoop_req),
    .snoop_hit       (snoop_hit),
    .snoop_supply    (snoop_supply),
    .snoop_data      (snoop_data),
    .mem_req_valid   (mem_req_valid),
    .mem_req_ready   (mem_req_ready),
    .mem_req_we      (mem_req_we),
    .mem_req_addr    (mem_req_addr),
    .mem_req_data    (mem_req_data),
    .mem_resp_valid  (mem_resp_valid),
    .mem_resp_data   (mem_resp_data)
  );

  typedef struct {
    int              core;
    bus_req_t        typ;
    logic [LA-1:0]   addr;
    logic [15:0]     wword;
    logic [3:0]      hit;
    logic [3:0]      sup;
    logic [3:0][15:0] sdat;
    int              acc_lat;
    int              data_lat;
    logic [15:0]     mword;
    int              path;
    logic [15:0]     exp_word;
    logic            exp_shared;
  } vec_t;

  int n_vec  = 0;
  int n_err  = 0;
  int tb_ptr = 0;

  function automatic logic [CL-1:0] line16(input logic [15:0] w);
    return {(CL/16){w}};
  endfunction

  task automatic chk(input string name, input logic [CL-1:0] act, input logic [CL-1:0] want);
    n_vec++;
    if (act !== want) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, want, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus_req_valid  = '0;
    bus_req_addr   = '0;
    bus_req_data   = '0;
    for (int c = 0; c < N; c++) bus_req[c] = BUS_RD;
    snoop_hit      = '0;
    snoop_supply   = '0;
    snoop_data     = '0;
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b0;
    mem_resp_data  = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    tb_ptr  = 0;
    tick();
  endtask

  function automatic vec_t mkv(input int core, input bus_req_t typ, input logic [LA-1:0] addr,
                               input logic [15:0] wword, input logic [3:0] hit, input logic [3:0] sup,
                               input logic [3:0][15:0] sdat, input int acc_lat, input int data_lat,
                               input logic [15:0] mword, input int path, input logic [15:0] exp_word,
                               input logic exp_shared);
    vec_t v;
    v.core = core; v.typ = typ; v.addr = addr; v.wword = wword; v.hit = hit; v.sup = sup;
    v.sdat = sdat; v.acc_lat = acc_lat; v.data_lat = data_lat; v.mword = mword;
    v.path = path; v.exp_word = exp_word; v.exp_shared = exp_shared;
    return v;
  endfunction

  // Reference model: what the bus must do for one transaction, from the
  // protocol rules (requester never snooped, lowest supplier wins, shared
  // only for plain reads).
  function automatic vec_t predict(input vec_t v);
    vec_t       r;
    logic [3:0] others;
    logic [3:0] s;
    r      = v;
    others = 4'hF & ~(4'b0001 << v.core);
    s      = v.sup & others;
    r.exp_shared = (v.typ == BUS_RD) && ((v.hit & others) != 4'b0);
    r.exp_word   = 16'h0;
    if (v.typ == BUS_WB)        r.path = P_WB;
    else if (v.typ == BUS_UPGR) r.path = P_UPGR;
    else if (s != 4'b0) begin
      r.path = P_SUP;
      for (int c = 3; c >= 0; c--) if (s[c]) r.exp_word = v.sdat[c];
    end else begin
      r.path     = P_MEM;
      r.exp_word = v.mword;
    end
    return r;
  endfunction

  task automatic mem_check(input vec_t v, input logic we);
    chk("mem_req_valid", mem_req_valid, 1'b1);
    chk("mem_req_we",    mem_req_we, we);
    chk("mem_req_addr",  mem_req_addr, v.addr);
    if (we) chk("mem_req_data", mem_req_data, line16(v.wword));
  endtask

  task automatic mem_phase(input vec_t v, input logic [3:0] oh);
    logic we;
    we = (v.path == P_WB);
    for (int i = 0; i < v.acc_lat; i++) begin
      mem_check(v, we);
      tick();
    end
    mem_req_ready = 1'b1;
    mem_check(v, we);
    tick();
    mem_req_ready = 1'b0;
    chk("mem_req_drop",      mem_req_valid, 1'b0);
    chk("no_resp_at_accept", bus_resp_valid, 4'b0);
    if (!we) begin
      for (int i = 1; i < v.data_lat; i++) begin
        tick();
        chk("resp_wait", bus_resp_valid, 4'b0);
      end
      mem_resp_valid = 1'b1;
      mem_resp_data  = line16(v.mword);
      tick();
      mem_resp_valid = 1'b0;
      mem_resp_data  = '0;
      chk("mem_resp_valid",  bus_resp_valid, oh);
      chk("mem_resp_data",   bus_resp_data, line16(v.exp_word));
      chk("mem_resp_shared", bus_resp_shared, v.exp_shared);
      tick();
      chk("mem_resp_once",   bus_resp_valid, 4'b0);
    end
  endtask

  // Called in an IDLE cycle at posedge+1; returns in the next IDLE cycle.
  task automatic run_txn(input vec_t v, input logic [3:0] vmask);
    int         g;
    logic [3:0] oh;
    g  = v.core;
    oh = 4'b0001 << g;
    for (int c = 0; c < N; c++) begin
      bus_req[c]      = (c == g) ? v.typ : bus_req_t'(2'($urandom_range(0, 3)));
      bus_req_addr[c] = (c == g) ? v.addr : LA'($urandom);
      bus_req_data[c] = (c == g) ? line16(v.wword) : line16(16'($urandom));
    end
    bus_req_valid = vmask;
    #1;
    chk("grant", bus_req_ready, oh);
    tick();
    bus_req_valid = '0;
    tb_ptr = (g + 1) % N;
    if (v.path == P_WB) begin
      chk("wb_no_snoop", snoop_valid, 4'b0);
      mem_phase(v, oh);
    end else begin
      chk("snoop_valid", snoop_valid, 4'hF & ~oh);
      chk("snoop_req",   snoop_req, v.typ);
      chk("snoop_addr",  snoop_addr, v.addr);
      chk("snoop_no_mem", mem_req_valid, 1'b0);
      tick();
      chk("snoop_once", snoop_valid, 4'b0);
      snoop_hit    = v.hit;
      snoop_supply = v.sup;
      for (int c = 0; c < N; c++) snoop_data[c] = line16(v.sdat[c]);
      tick();
      snoop_hit    = '0;
      snoop_supply = '0;
      snoop_data   = '0;
      case (v.path)
        P_UPGR: begin
          chk("upgr_no_resp", bus_resp_valid, 4'b0);
          chk("upgr_no_mem",  mem_req_valid, 1'b0);
        end
        P_SUP: begin
          chk("sup_resp_valid",  bus_resp_valid, oh);
          chk("sup_resp_data",   bus_resp_data, line16(v.exp_word));
          chk("sup_resp_shared", bus_resp_shared, v.exp_shared);
          chk("sup_no_mem",      mem_req_valid, 1'b0);
          tick();
          chk("sup_resp_once",   bus_resp_valid, 4'b0);
        end
        default: mem_phase(v, oh);
      endcase
    end
  endtask

  task automatic upgr_stream();
    int gcyc[$];
    int gcore[$];
    int resp_seen;
    resp_seen = 0;
    for (int c = 0; c < N; c++) begin
      bus_req[c]      = BUS_UPGR;
      bus_req_addr[c] = LA'(32'h100 + c);
    end
    bus_req_valid = 4'hF;
    for (int cyc = 0; cyc < 13; cyc++) begin
      #1;
      for (int c = 0; c < N; c++) begin
        if (bus_req_ready[c]) begin
          gcyc.push_back(cyc);
          gcore.push_back(c);
        end
      end
      if (bus_resp_valid != 4'b0) resp_seen++;
      tick();
    end
    bus_req_valid = '0;
    repeat (2) tick();
    tb_ptr = 1;
    chk("upgr_grant_count", gcore.size(), 5);
    for (int k = 0; k < gcore.size() && k < 5; k++) begin
      chk("upgr_grant_order", gcore[k], k % 4);
      chk("upgr_grant_cycle", gcyc[k], 3 * k);
    end
    chk("upgr_stream_no_resp", resp_seen, 0);
  endtask

  task automatic reset_mid_txn();
    bus_req[1]      = BUS_RD;
    bus_req_addr[1] = LA'(32'h2A);
    bus_req_valid   = 4'b0010;
    #1;
    chk("rst_seq_grant", bus_req_ready, 4'b0010);
    tick();
    bus_req_valid = '0;
    tick();
    snoop_hit = 4'b0001;
    tick();
    snoop_hit = '0;
    chk("rst_seq_mem_req", mem_req_valid, 1'b1);
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    for (int c = 0; c < N; c++) bus_req[c] = BUS_UPGR;
    bus_req_valid = 4'hF;
    #1;
    chk("busy_no_grant", bus_req_ready, 4'b0);
    #2;
    reset_n = 1'b0;
    #1;
    chk("rst_ready",  bus_req_ready, 4'b0);
    chk("rst_resp",   bus_resp_valid, 4'b0);
    chk("rst_shared", bus_resp_shared, 1'b0);
    chk("rst_snoop",  snoop_valid, 4'b0);
    chk("rst_mem",    mem_req_valid, 1'b0);
    mem_resp_valid = 1'b1;
    mem_resp_data  = line16(16'hEEEE);
    tick();
    mem_resp_valid = 1'b0;
    mem_resp_data  = '0;
    chk("rst_hold_no_resp", bus_resp_valid, 4'b0);
    #2;
    reset_n = 1'b1;
    #1;
    chk("post_rst_grant", bus_req_ready, 4'b0001);
    tick();
    bus_req_valid = '0;
    tb_ptr = 1;
    chk("post_rst_snoop", snoop_valid, 4'b1110);
    tick();
    tick();
    chk("post_rst_no_resp", bus_resp_valid, 4'b0);
  endtask

  task automatic run_random(input int n);
    vec_t       v;
    logic [3:0] vmask;
    int         g;
    for (int t = 0; t < n; t++) begin
      vmask = 4'($urandom_range(1, 15));
      g = -1;
      for (int i = 0; i < N; i++) begin
        if (g < 0 && vmask[(tb_ptr + i) % N]) g = (tb_ptr + i) % N;
      end
      v.core     = g;
      v.typ      = bus_req_t'(2'($urandom_range(0, 3)));
      v.addr     = LA'($urandom);
      v.wword    = 16'($urandom);
      v.hit      = 4'($urandom);
      v.sup      = 4'($urandom) & v.hit;
      for (int c = 0; c < N; c++) v.sdat[c] = 16'($urandom);
      v.acc_lat  = $urandom_range(0, 3);
      v.data_lat = $urandom_range(1, 3);
      v.mword    = 16'($urandom);
      v = predict(v);
      run_txn(v, vmask);
    end
  endtask

  vec_t tab [9];

  initial begin
    tab[0] = mkv(1, BUS_RD,   LA'(32'h12),  16'h0,    4'b0000, 4'b0000, '0,
                 0, 2, 16'hAAAA, P_MEM, 16'hAAAA, 1'b0);
    tab[1] = mkv(0, BUS_RD,   LA'(32'h12),  16'h0,    4'b0100, 4'b0100,
                 {16'h0000, 16'h5555, 16'h0000, 16'h0000},
                 0, 1, 16'h0,    P_SUP, 16'h5555, 1'b1);
    tab[2] = mkv(3, BUS_RDX,  LA'(32'h40),  16'h0,    4'b0001, 4'b0000, '0,
                 1, 1, 16'h3C3C, P_MEM, 16'h3C3C, 1'b0);
    tab[3] = mkv(2, BUS_WB,   LA'(32'h7),   16'hDEAD, 4'b0000, 4'b0000, '0,
                 3, 1, 16'h0,    P_WB,  16'h0,    1'b0);
    tab[4] = mkv(1, BUS_RD,   LA'(32'h99),  16'h0,    4'b0010, 4'b0010,
                 {16'h0000, 16'h0000, 16'hBAD1, 16'h0000},
                 0, 3, 16'h7777, P_MEM, 16'h7777, 1'b0);
    tab[5] = mkv(3, BUS_RD,   LA'(32'h123), 16'h0,    4'b1110, 4'b0110,
                 {16'hF00D, 16'h2222, 16'h1111, 16'h0000},
                 2, 1, 16'h9999, P_SUP, 16'h1111, 1'b1);
    tab[6] = mkv(2, BUS_UPGR, LA'(32'h55),  16'h0,    4'b1111, 4'b0000, '0,
                 0, 1, 16'h0,    P_UPGR, 16'h0,   1'b0);
    tab[7] = mkv(0, BUS_RDX,  LA'(32'h3FF), 16'h0,    4'b0010, 4'b0010,
                 {16'h0000, 16'h0000, 16'hC0DE, 16'h0000},
                 0, 1, 16'h0,    P_SUP, 16'hC0DE, 1'b0);
    tab[8] = mkv(2, BUS_RD,   LA'(32'h81),  16'h0,    4'b1001, 4'b0000, '0,
                 1, 2, 16'h4242, P_MEM, 16'h4242, 1'b1);

    clear_inputs();
    reset_n = 1'b0;
    bus_req_valid = 4'hF;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_ready",  bus_req_ready, 4'b0);
    chk("reset_resp",   bus_resp_valid, 4'b0);
    chk("reset_shared", bus_resp_shared, 1'b0);
    chk("reset_snoop",  snoop_valid, 4'b0);
    chk("reset_saddr",  snoop_addr, '0);
    chk("reset_mem",    mem_req_valid, 1'b0);
    chk("reset_mem_we", mem_req_we, 1'b0);
    bus_req_valid = '0;
    reset_n = 1'b1;
    tick();

    for (int i = 0; i < 9; i++) run_txn(tab[i], 4'b0001 << tab[i].core);

    do_reset();
    upgr_stream();
    reset_mid_txn();
    run_random(40);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
